// File: rtl/seq_borrow_ahead_subtractor_if.sv
// Start/done request and result bus for the sequential borrow-lookahead subtractor.
// Master drives the request; slave returns status and the registered result.
interface seq_borrow_ahead_subtractor_if #(
   parameter int unsigned WIDTH = 16
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             zero;
   logic             ovf;

   modport master (
      output start, a, b, bin,
      input  busy, done, diff, bout, zero, ovf
   );

   modport slave (
      input  start, a, b, bin,
      output busy, done, diff, bout, zero, ovf
   );
endinterface

// File: rtl/seq_borrow_ahead_subtractor.sv
// Multi-cycle WIDTH-bit subtractor: diff = a - b - bin, one 4-bit borrow-lookahead
// slice per clock, LSB first, with the slice borrow carried in a register.
module seq_borrow_ahead_subtractor #(
   parameter int unsigned WIDTH = 16
) (
   input logic                            clk,
   input logic                            rst,
   seq_borrow_ahead_subtractor_if.slave   bus
);
   localparam int unsigned NSLICE  = WIDTH / 4;
   localparam int unsigned SLICE_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam int unsigned BASE_W  = SLICE_W + 2;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q;
   logic [SLICE_W-1:0] slice_q;
   logic [WIDTH-1:0]   a_q, b_q, res_q;
   logic               borrow_q;
   logic               busy_q, done_q, bout_q, zero_q, ovf_q;
   logic [WIDTH-1:0]   diff_q;

   logic [BASE_W-1:0]  base_c;
   logic [3:0]         sa_c, sb_c, g_c, p_c, sd_c;
   logic [4:0]         bw_c;
   logic [WIDTH-1:0]   res_d;

   // Current slice: borrow lookahead from the registered borrow, then merge into the result.
   always_comb begin
      base_c = {slice_q, 2'b00};
      sa_c   = a_q[base_c +: 4];
      sb_c   = b_q[base_c +: 4];
      g_c    = ~sa_c & sb_c;
      p_c    = ~(sa_c ^ sb_c);
      bw_c[0] = borrow_q;
      bw_c[1] = g_c[0] | (p_c[0] & borrow_q);
      bw_c[2] = g_c[1] | (p_c[1] & g_c[0]) | (p_c[1] & p_c[0] & borrow_q);
      bw_c[3] = g_c[2] | (p_c[2] & g_c[1]) | (p_c[2] & p_c[1] & g_c[0])
              | (p_c[2] & p_c[1] & p_c[0] & borrow_q);
      bw_c[4] = g_c[3] | (p_c[3] & g_c[2]) | (p_c[3] & p_c[2] & g_c[1])
              | (p_c[3] & p_c[2] & p_c[1] & g_c[0])
              | (p_c[3] & p_c[2] & p_c[1] & p_c[0] & borrow_q);
      sd_c   = sa_c ^ sb_c ^ bw_c[3:0];
      res_d  = res_q;
      res_d[base_c +: 4] = sd_c;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         slice_q  <= '0;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         borrow_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         diff_q   <= '0;
         bout_q   <= 1'b0;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  a_q      <= bus.a;
                  b_q      <= bus.b;
                  borrow_q <= bus.bin;
                  slice_q  <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= RUN;
               end else begin
                  state_q  <= IDLE;
               end
            end
            RUN: begin
               res_q    <= res_d;
               borrow_q <= bw_c[4];
               // Outputs load together only on the final slice.
               if (slice_q == SLICE_W'(NSLICE - 1)) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  diff_q  <= res_d;
                  bout_q  <= bw_c[4];
                  zero_q  <= (res_d == '0);
                  ovf_q   <= (a_q[WIDTH-1] != b_q[WIDTH-1]) & (res_d[WIDTH-1] != a_q[WIDTH-1]);
               end else begin
                  slice_q <= slice_q + SLICE_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.diff = diff_q;
   assign bus.bout = bout_q;
   assign bus.zero = zero_q;
   assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_seq_borrow_ahead_subtractor.sv
// Directed bench for seq_borrow_ahead_subtractor (WIDTH=16) with hand-computed results.
module tb_seq_borrow_ahead_subtractor;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   seq_borrow_ahead_subtractor_if #(.WIDTH(16)) bus ();

   seq_borrow_ahead_subtractor #(.WIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive a start for one edge; returns #1 after the accepting edge.
   task automatic do_start(input logic [15:0] a, input logic [15:0] b, input logic bin);
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      bus.bin   = bin;
      tick();
      bus.start = 1'b0;
   endtask

   // Cycles from the accepting edge until done is seen, bounded.
   task automatic wait_done(output int k);
      k = 0;
      while (!bus.done && k < 20) begin
         tick();
         k++;
      end
   endtask

   task automatic check_result(input string tag, input logic [15:0] d, input logic bo,
                               input logic z, input logic o);
      check({tag, "_diff"}, 32'(bus.diff), 32'(d));
      check({tag, "_bout"}, 32'(bus.bout), 32'(bo));
      check({tag, "_zero"}, 32'(bus.zero), 32'(z));
      check({tag, "_ovf"},  32'(bus.ovf),  32'(o));
   endtask

   task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic bin, input logic [15:0] d, input logic bo,
                         input logic z, input logic o);
      int k;
      do_start(a, b, bin);
      check({tag, "_busy"}, 32'(bus.busy), 32'd1);
      wait_done(k);
      check({tag, "_lat"}, 32'(k), 32'd4);
      check({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
      check_result(tag, d, bo, z, o);
      tick();
      check({tag, "_done_drop"}, 32'(bus.done), 32'd0);
   endtask

   initial begin
      int k;
      int first_k;
      int pulses;
      n_checks  = 0;
      n_fail    = 0;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.bin   = 1'b0;
      tick();
      tick();
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check_result("rst", 16'h0000, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      tick();

      run_op("basic",   16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
      run_op("under",   16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
      run_op("sovf",    16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1);
      run_op("zero",    16'h5555, 16'h5555, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
      run_op("zero_bin",16'h5555, 16'h5555, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
      run_op("neg_ovf", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1);

      // Start during RUN is ignored.
      do_start(16'h9000, 16'h1000, 1'b0);
      first_k = -1;
      pulses  = 0;
      for (int i = 1; i <= 8; i++) begin
         if (i == 2) begin
            bus.start = 1'b1;
            bus.a     = 16'hFFFF;
            bus.b     = 16'h0000;
            bus.bin   = 1'b0;
         end
         tick();
         bus.start = 1'b0;
         if (bus.done) begin
            pulses++;
            if (first_k < 0) begin
               first_k = i;
               check_result("ign", 16'h8000, 1'b0, 1'b0, 1'b0);
            end
         end
      end
      check("ign_lat", 32'(first_k), 32'd4);
      check("ign_pulses", 32'(pulses), 32'd1);

      // Back-to-back: start held in the DONE cycle.
      do_start(16'h1234, 16'h0234, 1'b0);
      wait_done(k);
      check("b2b1_lat", 32'(k), 32'd4);
      check("b2b1_diff", 32'(bus.diff), 32'h1000);
      do_start(16'h00FF, 16'h0F00, 1'b0);
      check("b2b_busy", 32'(bus.busy), 32'd1);
      check("b2b_done_low", 32'(bus.done), 32'd0);
      check("b2b_hold0", 32'(bus.diff), 32'h1000);
      tick();
      tick();
      tick();
      check("b2b_hold3", 32'(bus.diff), 32'h1000);
      check("b2b_nodone3", 32'(bus.done), 32'd0);
      tick();
      check("b2b2_done", 32'(bus.done), 32'd1);
      check_result("b2b2", 16'hF1FF, 1'b1, 1'b0, 1'b0);
      tick();

      // Reset mid-RUN.
      do_start(16'h0000, 16'h0001, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mrst_busy", 32'(bus.busy), 32'd0);
      check("mrst_done", 32'(bus.done), 32'd0);
      check_result("mrst", 16'h0000, 1'b0, 1'b0, 1'b0);
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus.done) pulses++;
      end
      check("mrst_nopulse", 32'(pulses), 32'd0);
      run_op("post_rst", 16'hABCD, 16'h1111, 1'b1, 16'h9ABB, 1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
